mem_port_arbiter: RTL

//  Shares one line-wide memory port between the I-cache and D-cache miss engines.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, state/owner encodings and the round-robin pick used by mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // A lone request wins; on a tie the side that was not served last goes next.
    function automatic owner_e pick_owner(input logic ireq, input logic dreq, input owner_e last);
        owner_e win;
        if (ireq && dreq) begin
            win = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (dreq) begin
            win = OWN_D;
        end else begin
            win = OWN_I;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache miss engines:
// one grant at a time, a LATENCY-cycle strobed access, then a one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              m_readM,
    output logic              m_writeM,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            last_q, last_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    owner_e            winner;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= OWN_I;
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        m_readM  = 1'b0;
        m_writeM = 1'b0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        winner   = pick_owner(i_req, d_req, last_q);

        unique case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    owner_d = winner;
                    // Low address bits dropped so memory always moves a whole aligned line.
                    if (winner == OWN_D) begin
                        we_d    = d_we;
                        addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = i_we;
                        addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = i_wdata;
                    end
                end
            end
            ST_BUSY: begin
                m_readM  = ~we_q;
                m_writeM = we_q;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                last_d  = owner_q;
                if (owner_q == OWN_I) begin
                    i_ack   = 1'b1;
                    i_rdata = we_q ? '0 : rdata_q;
                end else begin
                    d_ack   = 1'b1;
                    d_rdata = we_q ? '0 : rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_address = addr_q;
    assign m_wdata   = wdata_q;

endmodule
